// File: rtl/button_shaper_multi.sv
// rtl/button_shaper_multi.sv - N-channel button synchroniser, debouncer and auto-repeat pulse shaper
module button_shaper_multi #(
    parameter int N_CH         = 4,
    parameter int DEBOUNCE_CYC = 16,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic            Clk,
    input  logic            rts,
    input  logic [N_CH-1:0] B_in,
    input  logic [N_CH-1:0] Repeat_en,
    output logic [N_CH-1:0] B_out,
    output logic [N_CH-1:0] B_held
);

    localparam int MAX_A = (DEBOUNCE_CYC > REPEAT_DELAY) ? DEBOUNCE_CYC : REPEAT_DELAY;
    localparam int MAX_P = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
    localparam int CW    = $clog2(MAX_P) + 1;

    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {IDLE, DEB_P, PRESSED, DEB_R} state_t;

    logic [N_CH-1:0] p_raw;
    logic [N_CH-1:0] s1;
    logic [N_CH-1:0] p_s;

    // Normalise polarity before synchronising so reset can load 0 as "released".
    assign p_raw = (ACTIVE_LOW != 0) ? ~B_in : B_in;

    always_ff @(posedge Clk or negedge rts) begin
        if (!rts) begin
            s1  <= '0;
            p_s <= '0;
        end else begin
            s1  <= p_raw;
            p_s <= s1;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        state_t        state;
        logic [CW-1:0] dcnt;
        logic [CW-1:0] rcnt;
        logic          rate_phase;
        logic          out_q;
        logic          held_q;

        assign B_out[i]  = out_q;
        assign B_held[i] = held_q;

        always_ff @(posedge Clk or negedge rts) begin
            if (!rts) begin
                state      <= IDLE;
                dcnt       <= '0;
                rcnt       <= '0;
                rate_phase <= 1'b0;
                out_q      <= 1'b0;
                held_q     <= 1'b0;
            end else begin
                out_q <= 1'b0;
                case (state)
                    IDLE: begin
                        held_q <= 1'b0;
                        if (p_s[i]) begin
                            state <= DEB_P;
                            dcnt  <= '0;
                        end
                    end
                    DEB_P: begin
                        if (!p_s[i]) begin
                            state <= IDLE;
                        end else if (dcnt == DEB_LAST) begin
                            state      <= PRESSED;
                            out_q      <= 1'b1;
                            held_q     <= 1'b1;
                            rcnt       <= '0;
                            rate_phase <= 1'b0;
                        end else begin
                            dcnt <= dcnt + CW'(1);
                        end
                    end
                    PRESSED: begin
                        // A release start wins over a repeat that would fall on the same edge.
                        if (!p_s[i]) begin
                            state <= DEB_R;
                            dcnt  <= '0;
                        end else if (Repeat_en[i]) begin
                            if (rcnt == (rate_phase ? RATE_LAST : DELAY_LAST)) begin
                                out_q      <= 1'b1;
                                rcnt       <= '0;
                                rate_phase <= 1'b1;
                            end else begin
                                rcnt <= rcnt + CW'(1);
                            end
                        end else begin
                            rcnt       <= '0;
                            rate_phase <= 1'b0;
                        end
                    end
                    DEB_R: begin
                        if (p_s[i]) begin
                            state      <= PRESSED;
                            rcnt       <= '0;
                            rate_phase <= 1'b0;
                        end else if (dcnt == DEB_LAST) begin
                            state  <= IDLE;
                            held_q <= 1'b0;
                        end else begin
                            dcnt <= dcnt + CW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/button_shaper_multi.md
Name: button_shaper_multi

Overview:
Multi-channel successor to the single-input button shaper. Synchronises N raw push-button inputs, debounces press and release with a programmable cycle count, and emits one-cycle press pulses. Optional per-channel auto-repeat generates further pulses while a button stays held. Sits between the board push-buttons and the game/password control FSMs, replacing one shaper instance per button.

Parameters:
N_CH, 4, number of independent button channels (>=1)
DEBOUNCE_CYC, 16, consecutive stable cycles required to accept a press or a release (>=1)
REPEAT_DELAY, 500, cycles from the initial press pulse to the first repeat pulse (>=2)
REPEAT_RATE, 100, cycles between later repeat pulses (>=2)
ACTIVE_LOW, 1, 1: B_in level 0 means pressed; 0: level 1 means pressed

Ports:
Clk  input  1  system clock; all state changes on the rising edge
rts  input  1  asynchronous active-low reset
B_in  input  N_CH  raw asynchronous button levels, one bit per channel
Repeat_en  input  N_CH  per-channel auto-repeat enable, synchronous to Clk
B_out  output  N_CH  registered one-cycle press/repeat pulses, active-high
B_held  output  N_CH  registered debounced "button held" level, active-high

Behaviour:
- Reset: rts low → all channels to IDLE, counters 0, B_out=0, B_held=0. Sync flops load the released level, whatever ACTIVE_LOW is. Reset overrides everything, including mid-debounce and mid-repeat.
- Button held while rts rises: treated as a new press. One pulse after the normal debounce latency.
- Sync: 2-flop synchroniser per bit, normalised to p=1 when pressed. The FSM uses only the second flop (p_s).
- Each channel is independent. Per-channel state: 2-bit state, debounce counter dcnt, repeat counter rcnt. Counter widths sized by $clog2 of the largest parameter + 1.
- States per channel:
  - IDLE: B_held=0. If p_s=1 → DEB_P, dcnt=0.
  - DEB_P: if p_s=0 → IDLE (glitch rejected, no pulse). Otherwise dcnt++. On the edge where dcnt==DEBOUNCE_CYC-1 → PRESSED, B_out<=1 for one cycle, rcnt=0.
  - PRESSED: B_held=1. If p_s=0 → DEB_R, dcnt=0; rcnt frozen; any repeat due that cycle is suppressed.
    - If Repeat_en=1: rcnt++. On rcnt==REPEAT_DELAY-1 (first repeat) or REPEAT_RATE-1 (later repeats) → B_out<=1, rcnt=0, phase=rate.
    - If Repeat_en=0: rcnt=0, phase=delay. Re-enabling restarts the full REPEAT_DELAY.
  - DEB_R: B_held stays 1. If p_s=1 → PRESSED, no new pulse, rcnt and phase reset. Otherwise dcnt++. On dcnt==DEBOUNCE_CYC-1 → IDLE, B_held<=0.
- Press latency: let E0 be the first Clk edge that samples B_in pressed. B_out is high for exactly the cycle starting at edge E0+DEBOUNCE_CYC+2, and B_held rises on that same edge.
- Release latency: B_held falls at edge R0+DEBOUNCE_CYC+2, where R0 is the first edge that samples B_in released.
- B_out is never high for two consecutive cycles on a channel (REPEAT_RATE>=2).
- Simultaneous presses on several channels are handled in parallel. There is no arbitration.
- B_out and B_held come straight from flops, with no combinational path from inputs.

Test Plan:
(Bench parameters: N_CH=2, DEBOUNCE_CYC=4, REPEAT_DELAY=8, REPEAT_RATE=3, ACTIVE_LOW=1, 20 ns clock.)
- Reset then clean press: rts low 2 cycles, then high. Drive B_in[0]=0, first sampled at edge E0 → B_out[0]=1 only in the cycle after edge E0+6; B_held[0]=1 from E0+6; B_out[1] stays 0.
- Glitch rejection: B_in[0] low for 3 cycles, then high → B_out[0] and B_held[0] stay 0 throughout; channel returns to IDLE.
- Release bounce: while held, B_in[0] high for 2 cycles then low again → B_held[0] stays 1, no extra B_out pulse. Then a stable release → B_held[0]=0 at R0+6.
- Auto-repeat: Repeat_en[1]=1, hold B_in[1] low for 30 cycles → initial pulse, then pulses 8 cycles later, then every 3 cycles. Pulse count matches the model; no pulse after the release starts.
- Repeat disable and re-enable mid-hold: drop Repeat_en[1] for 5 cycles → no pulses during the gap. After re-assertion, the next pulse comes 8 cycles later, not 3.
- Reset mid-operation: assert rts during channel 0 DEB_P and channel 1 repeat → B_out=0 and B_held=0 immediately (asynchronous). Hold buttons through the rts release → one fresh pulse each, 6 edges after the first post-reset sample.
